trigger_gen: RTL and testbench

- Drives the ultrasonic sensor TRIG pin and sequences a complete ranging cycle: trigger pulse, wait for echo rise, wait for echo fall or timeout, then enforced hold-off before the next ping.
- Sits beside the echo pulse-width counter in the wb_trigger block. This block owns the transmit side and cycle timing; the counter measures the echo width.
- Exposes start/continuous control and busy/done/timeout status for the Wishbone register layer.

---
 rtl/wb_trigger_pkg.sv | 23 ++
 rtl/trigger_gen_if.sv | 28 ++
 rtl/us_tick_gen.sv | 31 +++
 rtl/trigger_gen.sv | 141 ++++++++++++++
 tb/tb_trigger_gen.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_trigger_pkg.sv
// Shared definitions for the wb_trigger block: ranging FSM state encoding and
// the default ultrasonic sensor timing used by the trigger, echo counter and registers.
package wb_trigger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_WAIT_FALL = 3'd3,
        ST_HOLDOFF   = 3'd4
    } trig_state_t;

    localparam int unsigned DEF_CLK_PER_US  = 50;
    localparam int unsigned DEF_TRIG_US     = 10;
    localparam int unsigned DEF_ECHO_TMO_US = 38000;
    localparam int unsigned DEF_PERIOD_US   = 60000;

    // Value the microsecond counter holds on the tick that makes it reach `us`.
    function automatic logic [15:0] us_last(input int unsigned us);
        return 16'(us - 1);
    endfunction

endpackage

// File: rtl/trigger_gen_if.sv
// Control/status and sensor-pin bundle of trigger_gen; the master side is the
// register layer plus sensor, the slave side is the trigger generator itself.
interface trigger_gen_if;
    import wb_trigger_pkg::*;

    // start is a request that is accepted only while busy is low (IDLE); a start
    // seen while busy is high is dropped, not queued. done/timeout are one-cycle
    // pulses and need no acknowledge.
    logic        start;
    logic        continuous;
    logic        echo_in;
    logic        trig_out;
    logic        busy;
    logic        done;
    logic        timeout;
    trig_state_t state;

    modport master (
        output start, continuous, echo_in,
        input  trig_out, busy, done, timeout, state
    );

    modport slave (
        input  start, continuous, echo_in,
        output trig_out, busy, done, timeout, state
    );

endinterface

// File: rtl/us_tick_gen.sv
// Microsecond timebase: free-running prescaler with synchronous clear that
// raises tick for one cycle out of every CLK_PER_US clocks.
module us_tick_gen
    import wb_trigger_pkg::*;
#(
    parameter int unsigned CLK_PER_US = DEF_CLK_PER_US
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     PW      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_PER_US - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            pre <= '0;
        end else if (clr || (pre == PRE_MAX)) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == PRE_MAX);

endmodule

// File: rtl/trigger_gen.sv
// Ultrasonic ranging sequencer: TRIG pulse, echo rise/fall wait with timeout,
// then hold-off until PERIOD_US has elapsed since the trigger rise.
module trigger_gen
    import wb_trigger_pkg::*;
#(
    parameter int unsigned CLK_PER_US  = DEF_CLK_PER_US,
    parameter int unsigned TRIG_US     = DEF_TRIG_US,
    parameter int unsigned ECHO_TMO_US = DEF_ECHO_TMO_US,
    parameter int unsigned PERIOD_US   = DEF_PERIOD_US
) (
    input  logic          clk_in,
    input  logic          reset,
    trigger_gen_if.slave  bus
);

    localparam logic [15:0] TRIG_LAST   = us_last(TRIG_US);
    localparam logic [15:0] TMO_LAST    = us_last(TRIG_US + ECHO_TMO_US);
    localparam logic [15:0] PERIOD_LAST = us_last(PERIOD_US);

    trig_state_t state;
    logic        trig_q;
    logic        busy_q;
    logic        done_q;
    logic        timeout_q;

    logic        echo_meta;
    logic        echo_s;

    logic        tick;
    logic        accept;
    logic [15:0] t_us;

    logic        trig_end;
    logic        tmo_hit;
    logic        period_end;

    assign accept = (state == ST_IDLE) && (bus.start || bus.continuous);

    us_tick_gen #(
        .CLK_PER_US (CLK_PER_US)
    ) u_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (accept),
        .tick   (tick)
    );

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
        end else begin
            echo_meta <= bus.echo_in;
            echo_s    <= echo_meta;
        end
    end

    // Elapsed microseconds since the trigger rise; saturating so a stalled
    // cycle can never wrap back into a compare window.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            t_us <= '0;
        end else if (accept) begin
            t_us <= '0;
        end else if (tick && (t_us != 16'hFFFF)) begin
            t_us <= t_us + 16'd1;
        end
    end

    // Each limit fires on the tick that carries t_us onto it, so the state
    // change lands on the very edge where the limit is reached.
    assign trig_end   = tick && (t_us == TRIG_LAST);
    assign tmo_hit    = tick && (t_us == TMO_LAST);
    assign period_end = tick && (t_us == PERIOD_LAST);

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state     <= ST_IDLE;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_TRIG;
                        trig_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ST_TRIG: begin
                    if (trig_end) begin
                        state  <= ST_WAIT_RISE;
                        trig_q <= 1'b0;
                    end
                end
                ST_WAIT_RISE: begin
                    // Timeout first: a rise on the last cycle could never be timed out later.
                    if (tmo_hit) begin
                        state     <= ST_HOLDOFF;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else if (echo_s) begin
                        state <= ST_WAIT_FALL;
                    end
                end
                ST_WAIT_FALL: begin
                    if (!echo_s) begin
                        state  <= ST_HOLDOFF;
                        done_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state     <= ST_HOLDOFF;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (period_end) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    trig_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trig_out = trig_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.timeout  = timeout_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_trigger_gen.sv
// Bench for trigger_gen: event times predicted from the ranging timing rules
// and compared against trigger/done/busy edges recorded from the DUT.
module tb_trigger_gen;
    import wb_trigger_pkg::*;

    localparam int N      = 4;
    localparam int TRIG   = 10;
    localparam int TMO    = 100;
    localparam int PERIOD = 200;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    int   edge_cnt = 0;
    int   n_total  = 0;
    int   n_bad    = 0;
    int   stray_tmo = 0;
    logic prev_trig = 1'b0;
    logic prev_busy = 1'b0;

    int          obs_rise_q[$], obs_fall_q[$], obs_busy_q[$], obs_done_q[$];
    logic [31:0] obs_tmo_q[$];
    logic [31:0] exp_rise_q[$], exp_fall_q[$], exp_busy_q[$], exp_done_q[$], exp_tmo_q[$];

    trigger_gen_if bus();

    trigger_gen #(
        .CLK_PER_US  (N),
        .TRIG_US     (TRIG),
        .ECHO_TMO_US (TMO),
        .PERIOD_US   (PERIOD)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    // Record output events tagged with the index of the posedge that produced them.
    always @(negedge clk_in) begin
        if (bus.trig_out === 1'b1 && !prev_trig) obs_rise_q.push_back(edge_cnt);
        if (bus.trig_out === 1'b0 && prev_trig)  obs_fall_q.push_back(edge_cnt);
        if (bus.busy === 1'b0 && prev_busy)      obs_busy_q.push_back(edge_cnt);
        if (bus.done === 1'b1) begin
            obs_done_q.push_back(edge_cnt);
            obs_tmo_q.push_back({31'd0, bus.timeout});
        end
        if (bus.timeout === 1'b1 && bus.done !== 1'b1) stray_tmo <= stray_tmo + 1;
        prev_trig <= (bus.trig_out === 1'b1);
        prev_busy <= (bus.busy === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Returns at the negedge following posedge e-1, so a drive lands at posedge e.
    task automatic drive_at(input int e);
        while (edge_cnt < e - 1) @(negedge clk_in);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 3000) check("idle_wait", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic fire(output int r);
        wait_idle();
        bus.start = 1'b1;
        r = edge_cnt + 1;
        @(negedge clk_in);
        bus.start = 1'b0;
    endtask

    // One ranging cycle starting at trigger rise edge r; echo timing in cycles after trigger fall.
    task automatic ping(input int r, input int rise_off, input int width,
                        input bit has_rise, input bit has_fall);
        int tf, lim, re, fe;
        tf  = r + TRIG * N;
        lim = r + (TRIG + TMO) * N;
        re  = tf + rise_off;
        fe  = re + width;
        exp_rise_q.push_back(r);
        exp_fall_q.push_back(tf);
        exp_busy_q.push_back(r + PERIOD * N);
        // Synchronizer: a level sampled at edge k is acted on at edge k+2; a fall on the limit edge wins.
        if (has_rise && has_fall && (fe + 2 <= lim)) begin
            exp_done_q.push_back(fe + 2);
            exp_tmo_q.push_back(32'd0);
        end else begin
            exp_done_q.push_back(lim);
            exp_tmo_q.push_back(32'd1);
        end
        if (has_rise) begin
            drive_at(re);
            bus.echo_in = 1'b1;
            if (has_fall) begin
                drive_at(fe);
                bus.echo_in = 1'b0;
            end
        end
        drive_at(r + PERIOD * N - 20);
        bus.echo_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        check({tag, " rises"}, obs_rise_q.size(), exp_rise_q.size());
        while (obs_rise_q.size() > 0 && exp_rise_q.size() > 0)
            check({tag, " rise_edge"}, obs_rise_q.pop_front(), exp_rise_q.pop_front());
        check({tag, " falls"}, obs_fall_q.size(), exp_fall_q.size());
        while (obs_fall_q.size() > 0 && exp_fall_q.size() > 0)
            check({tag, " fall_edge"}, obs_fall_q.pop_front(), exp_fall_q.pop_front());
        check({tag, " busy_falls"}, obs_busy_q.size(), exp_busy_q.size());
        while (obs_busy_q.size() > 0 && exp_busy_q.size() > 0)
            check({tag, " busy_edge"}, obs_busy_q.pop_front(), exp_busy_q.pop_front());
        check({tag, " dones"}, obs_done_q.size(), exp_done_q.size());
        while (obs_done_q.size() > 0 && exp_done_q.size() > 0) begin
            check({tag, " done_edge"}, obs_done_q.pop_front(), exp_done_q.pop_front());
            check({tag, " timeout"}, obs_tmo_q.pop_front(), exp_tmo_q.pop_front());
        end
        obs_rise_q.delete(); obs_fall_q.delete(); obs_busy_q.delete();
        obs_done_q.delete(); obs_tmo_q.delete();
        exp_rise_q.delete(); exp_fall_q.delete(); exp_busy_q.delete();
        exp_done_q.delete(); exp_tmo_q.delete();
    endtask

    task automatic shot(input string tag, input int rise_off, input int width,
                        input bit has_rise, input bit has_fall);
        int r;
        fire(r);
        ping(r, rise_off, width, has_rise, has_fall);
        drive_at(r + PERIOD * N + 5);
        drain(tag);
    endtask

    initial begin
        int r, r2, r3;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.echo_in    = 1'b0;
        repeat (5) @(negedge clk_in);
        check("rst trig_out", {31'd0, bus.trig_out}, 32'd0);
        check("rst busy",     {31'd0, bus.busy},     32'd0);
        check("rst done",     {31'd0, bus.done},     32'd0);
        check("rst timeout",  {31'd0, bus.timeout},  32'd0);
        check("rst state",    {29'd0, bus.state},    {29'd0, ST_IDLE});
        reset = 1'b1;
        @(negedge clk_in);

        shot("single",   80, 200, 1'b1, 1'b1);
        shot("no_echo",   0,   0, 1'b0, 1'b0);
        shot("stuck",    40,   0, 1'b1, 1'b0);
        shot("rise0",     0,  60, 1'b1, 1'b1);
        shot("width1",   30,   1, 1'b1, 1'b1);
        shot("fall_lim", 10, 388, 1'b1, 1'b1);
        shot("fall_late",10, 389, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            shot($sformatf("rand%0d", i), $urandom_range(0, 300), $urandom_range(1, 420), 1'b1, 1'b1);

        // Continuous: three cycles, continuous dropped during the third.
        wait_idle();
        bus.continuous = 1'b1;
        r = edge_cnt + 1;
        ping(r, 80, 120, 1'b1, 1'b1);
        r2 = r + PERIOD * N + 1;
        ping(r2, 80, 120, 1'b1, 1'b1);
        r3 = r2 + PERIOD * N + 1;
        drive_at(r3 + 5);
        bus.continuous = 1'b0;
        ping(r3, 80, 120, 1'b1, 1'b1);
        drive_at(r3 + 2 * PERIOD * N + 50);
        drain("cont");

        // Start pulses during TRIG/HOLDOFF and an echo glitch during TRIG are ignored.
        fire(r);
        exp_rise_q.push_back(r);
        exp_fall_q.push_back(r + TRIG * N);
        exp_busy_q.push_back(r + PERIOD * N);
        exp_done_q.push_back(r + (TRIG + TMO) * N);
        exp_tmo_q.push_back(32'd1);
        drive_at(r + 10);  bus.start = 1'b1;
        drive_at(r + 11);  bus.start = 1'b0;
        drive_at(r + 12);  bus.echo_in = 1'b1;
        drive_at(r + 16);  bus.echo_in = 1'b0;
        drive_at(r + 600); bus.start = 1'b1;
        drive_at(r + 601); bus.start = 1'b0;
        drive_at(r + PERIOD * N + 30);
        drain("ignored");

        // Reset in the middle of the trigger pulse.
        fire(r);
        exp_rise_q.push_back(r);
        exp_fall_q.push_back(r + 20);
        exp_busy_q.push_back(r + 20);
        drive_at(r + 20);
        reset = 1'b0;
        @(negedge clk_in);
        check("midrst trig_out", {31'd0, bus.trig_out}, 32'd0);
        check("midrst busy",     {31'd0, bus.busy},     32'd0);
        check("midrst state",    {29'd0, bus.state},    {29'd0, ST_IDLE});
        reset = 1'b1;
        drive_at(r + 30);
        drain("midrst");
        shot("post_rst", 40, 100, 1'b1, 1'b1);

        check("stray timeout", stray_tmo, 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
